// File: rtl/data_sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_like_slave
// Purpose  : SRAM-like data-side responder with in-order, delayed responses.
// Revision : 1.0 - initial release
// ============================================================================

module data_sram_like_slave #(
  parameter int         AW          = 10,
  parameter int         OUTSTANDING = 2,
  parameter bit         RAND_EN     = 1'b0,
  parameter int         FIXED_DELAY = 1,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int            PW       = (OUTSTANDING > 2) ? 2 : 1;
  localparam logic [2:0]    OUT_N    = 3'(OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTSTANDING - 1);
  localparam logic [7:0]    FD_M1    = 8'(FIXED_DELAY - 1);

  logic [31:0]   mem_q   [2**AW];
  logic [31:0]   qdata_q [OUTSTANDING];
  logic [7:0]    qcnt_q  [OUTSTANDING];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]    qnum_q, qnum_d;   // entries not yet presented on data_ok
  logic [2:0]    cnt_q, cnt_d;     // accepted and not yet past their data_ok cycle
  logic [1:0]    gap_q, gap_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          err_q, err_d, data_ok_q, data_ok_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic          w_misal, w_accept, w_pop, w_bypass, w_push;
  logic [31:0]   w_ld_data;
  logic [7:0]    w_dly_m1;
  logic [1:0]    w_gap_new;
  logic          w_unused_addr;

  always_comb begin
    w_be = 4'b1111;
    case (size_i)
      2'd0:    w_be = 4'b0001 << addr_i[1:0];
      2'd1:    w_be = addr_i[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_misal   = ((size_i == 2'd1) && addr_i[0]) || (size_i[1] && (addr_i[1:0] != 2'b00));
  assign w_idx     = addr_i[AW+1:2];
  assign w_ld_data = (wr_i || w_misal) ? 32'd0 : mem_q[w_idx];
  assign w_dly_m1  = RAND_EN ? {5'd0, lfsr_q[2:0]} : FD_M1;
  assign w_gap_new = RAND_EN ? lfsr_q[5:4] : 2'd0;

  assign addr_ok_o = resetn && (cnt_q < OUT_N) && (gap_q == 2'd0);
  assign w_accept  = req_i && addr_ok_o;
  // A head at 1 still has one cycle to go, which the data_ok register supplies.
  assign w_pop     = (qnum_q != 3'd0) && (qcnt_q[head_q] <= 8'd1);
  assign w_bypass  = w_accept && (qnum_q == 3'd0) && (w_dly_m1 == 8'd0);
  assign w_push    = w_accept && !w_bypass;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    qnum_d    = qnum_q + {2'd0, w_push} - {2'd0, w_pop};
    cnt_d     = cnt_q + {2'd0, w_accept} - {2'd0, data_ok_q};
    gap_d     = w_accept ? w_gap_new : ((gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0);
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    err_d     = err_q || (w_accept && w_misal);
    data_ok_d = w_pop || w_bypass;
    rdata_d   = 32'd0;
    if (w_pop) begin
      rdata_d = qdata_q[head_q];
      head_d  = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end else if (w_bypass) begin
      rdata_d = w_ld_data;
    end
    if (w_push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      qnum_q    <= 3'd0;
      cnt_q     <= 3'd0;
      gap_q     <= 2'd0;
      lfsr_q    <= LFSR_SEED;
      err_q     <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      qnum_q    <= qnum_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      err_q     <= err_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  // Payload slots are only read while counted by qnum_q, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (qcnt_q[i] != 8'd0) qcnt_q[i] <= qcnt_q[i] - 8'd1;
    end
    if (w_push) begin
      qdata_q[tail_q] <= w_ld_data;
      qcnt_q[tail_q]  <= w_dly_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && wr_i && !w_misal) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign data_ok_o     = data_ok_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign w_unused_addr = ^addr_i[31:AW+2];

endmodule

`default_nettype wire

// File: tb/tb_data_sram_like_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_like_slave
// Purpose  : Scoreboard bench for data_sram_like_slave (fixed and random modes).
// Revision : 1.0 - initial release
// ============================================================================

module tb_data_sram_like_slave;

  localparam int NI = 3;  // 0: FIXED_DELAY=1, 1: FIXED_DELAY=4, 2: random, 4 outstanding

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  int          sel;
  logic [NI-1:0] aok, dok, err;
  logic [31:0] rdat [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    data_sram_like_slave #(
      .AW(10), .OUTSTANDING((k == 2) ? 4 : 2), .RAND_EN(k == 2),
      .FIXED_DELAY((k == 1) ? 4 : 1), .LFSR_SEED(8'hA5)
    ) u_dut (
      .clk(clk), .resetn(resetn), .req_i(req && (sel == k)), .wr_i(wr),
      .size_i(size), .addr_i(addr), .wdata_i(wdata),
      .addr_ok_o(aok[k]), .data_ok_o(dok[k]), .rdata_o(rdat[k]), .err_o(err[k])
    );
  end

  typedef struct { logic [31:0] data; int lo; int hi; } exp_t;
  exp_t        sbq[$];
  logic [31:0] mmem [NI][1024];
  bit          merr [NI];
  int          last_lo = -100, last_hi = -100;
  int          cyc = 0;
  int          n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference behaviour of one accepted request, from the byte-lane and delay rules.
  function automatic void model_accept(int k, int t, logic w, logic [1:0] sz,
                                       logic [31:0] a, logic [31:0] d);
    exp_t e;
    int   idx;
    bit   mis, en;
    idx = int'(a[11:2]);
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
    if (mis) merr[k] = 1'b1;
    e.data = 32'd0;
    if (!w && !mis) e.data = mmem[k][idx];
    if (w && !mis) begin
      for (int b = 0; b < 4; b++) begin
        case (sz)
          2'd0:    en = (b == int'(a[1:0]));
          2'd1:    en = ((b / 2) == int'(a[1]));
          default: en = 1'b1;
        endcase
        if (en) mmem[k][idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    if (k == 2) begin
      e.lo = (t + 1 > last_lo + 1) ? t + 1 : last_lo + 1;
      e.hi = (t + 8 > last_hi + 1) ? t + 8 : last_hi + 1;
    end else begin
      e.lo = (t + ((k == 1) ? 4 : 1) > last_hi + 1) ? t + ((k == 1) ? 4 : 1) : last_hi + 1;
      e.hi = e.lo;
    end
    last_lo = e.lo;
    last_hi = e.hi;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    for (int k = 0; k < NI; k++) begin
      if (dok[k] === 1'b1) begin
        if (k != sel || sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_data_ok: got data_ok on dut %0d in cycle %0d, expected none", k, cyc);
        end else begin
          e = sbq.pop_front();
          check("rdata", rdat[k], e.data);
          n_chk++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_fail++;
            $display("FAIL data_ok_cycle: got cycle %0d, expected %0d..%0d", cyc, e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output int tacc);
    int waited;
    waited = 0;
    tacc   = -1;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    forever begin
      @(negedge clk);
      if (aok[sel]) begin
        model_accept(sel, cyc, w, sz, a, d);
        tacc = cyc;
        break;
      end
      waited++;
      if (waited > 50) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: got no addr_ok in 50 cycles on dut %0d, expected accept", sel);
        break;
      end
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses pending, expected 0", sbq.size());
      sbq.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, tp, tn;
    for (int k = 0; k < NI; k++) begin
      merr[k] = 1'b0;
      for (int i = 0; i < 1024; i++) mmem[k][i] = 32'd0;
    end
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_addr_ok%0d", k), 32'(aok[k]), 32'd0);
      check($sformatf("reset_data_ok%0d", k), 32'(dok[k]), 32'd0);
      check($sformatf("reset_rdata%0d", k), rdat[k], 32'd0);
      check($sformatf("reset_err%0d", k), 32'(err[k]), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    check("addr_ok_first_cycle", 32'(aok), 32'h7);
    @(posedge clk); #1;

    // Fixed delay 1: word, byte and halfword lanes, back-to-back throughput
    sel = 0;
    issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, t0);
    issue(1'b0, 2'd2, 32'h10, 32'h0, t0);
    issue(1'b1, 2'd0, 32'h11, 32'h0000AA00, t0);
    issue(1'b1, 2'd1, 32'h12, 32'h12340000, t0);
    issue(1'b0, 2'd2, 32'h10, 32'h0, tp);
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 2'd2, 32'h10, 32'h0, tn);
      check("b2b_accept_cycle", 32'(tn), 32'(tp + 1));
      tp = tn;
    end
    drain();

    // Misaligned accesses: answered with 0, no write, sticky err
    issue(1'b0, 2'd2, 32'h13, 32'h0, t0);
    check("err_after_misaligned", 32'(err[0]), 32'd1);
    issue(1'b1, 2'd2, 32'h12, 32'hFFFFFFFF, t0);
    issue(1'b0, 2'd2, 32'h10, 32'h0, t0);
    drain();
    check("err_sticky", 32'(err[0]), 32'd1);

    // Fixed delay 4, two outstanding: back-pressure
    sel = 1;
    issue(1'b1, 2'd2, 32'h20, 32'hCAFEF00D, t0);
    drain();
    issue(1'b0, 2'd2, 32'h20, 32'h0, t0);
    issue(1'b0, 2'd2, 32'h20, 32'h0, t1);
    issue(1'b0, 2'd2, 32'h20, 32'h0, t2);
    check("bp_second_accept", 32'(t1 - t0), 32'd1);
    check("bp_third_accept", 32'(t2 - t0), 32'd5);
    drain();

    // Reset with two loads outstanding: responses discarded, memory kept
    issue(1'b0, 2'd2, 32'h20, 32'h0, t0);
    issue(1'b0, 2'd2, 32'h20, 32'h0, t1);
    @(posedge clk); #1;
    resetn = 1'b0;
    sbq.delete();
    for (int k = 0; k < NI; k++) merr[k] = 1'b0;
    last_lo = -100;
    last_hi = -100;
    @(negedge clk);
    check("addr_ok_in_reset", 32'(aok[1]), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("addr_ok_after_reset", 32'(aok), 32'h7);
    check("err_cleared_by_reset", 32'(err[0]), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 32'h20, 32'h0, t0);
    drain();
    sel = 0;
    issue(1'b0, 2'd2, 32'h10, 32'h0, t0);
    drain();

    // Random mode: mixed traffic with gaps against the reference model
    sel = 2;
    for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom, t0);
    for (int n = 0; n < 2000; n++) begin
      logic        w;
      logic [1:0]  sz;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'hFFFF_F03F;
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      issue(w, sz, a, $urandom, t0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    check("random_err_flag", 32'(err[2]), 32'(merr[2]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
